// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding read at a
// time to the word-addressed instruction RAM, buffers returned words with
// their PC in a small FIFO and hands them to decode over valid/ready.
// A branch redirect flushes buffered words and discards any in-flight read.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_req, mem_addr     read request (held until mem_rvalid) and word address
//   mem_rvalid, mem_rdata read response, may arrive in the same cycle as mem_req
//   redirect, redirect_pc branch-taken pulse and new fetch address
//   inst_valid/ready      handshake toward decode
//   inst_data, inst_pc    FIFO head word and its address (0 when not valid)
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned     PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic              drop_q, drop_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count, count_d, cnt_push;
  logic              push, pop, flush;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Occupancy if the current response is pushed (used to decide re-issue)
  assign cnt_push = count + CNT_W'(1) - CNT_W'(pop);

  // Next-state, fetch PC and FIFO control
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = inst_valid && inst_ready;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (count < FULL) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          if (mem_rvalid) begin
            // Response consumed and discarded this very cycle
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // Let the in-flight read finish, then throw it away
            drop_d = 1'b1;
          end
        end else if (mem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            if (cnt_push >= FULL) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) count_d = '0;
    else       count_d = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      count      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      count      <= count_d;
      // Freeze the outstanding address while a dropped read completes
      if (!drop_q) req_pc_q <= fetch_pc_q;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage; when full with a pop, the write lands in the freed head slot
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      data_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_req    = (state_q == WAIT);
  assign mem_addr   = drop_q ? req_pc_q : fetch_pc_q;
  assign inst_valid = (count != '0);
  assign inst_data  = inst_valid ? data_mem[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instruction RAM whose
// response latency is programmable (0 = same-cycle combinational read).
module tb_instr_fetch;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int viol    = 0;
  int mem_lat = 0;
  int wait_cnt = 0;

  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  int          got_t[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // RAM model: data is a fixed function of the address
  always_comb begin
    mem_rdata  = word_of(mem_addr);
    mem_rvalid = mem_req && (wait_cnt >= mem_lat);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !mem_req || mem_rvalid) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  // FIFO protocol watch: no push into a full FIFO without a pop, no pop when empty
  always @(posedge clk) begin
    if (!rst) begin
      if (dut.push && (dut.count == 2'(DEPTH)) && !dut.pop) viol <= viol + 1;
      if (dut.pop && (dut.count == 2'd0))                   viol <= viol + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input int n, input int budget);
    got_pc.delete();
    got_data.delete();
    got_t.delete();
    for (int c = 0; c < budget && got_pc.size() < n; c++) begin
      if (inst_valid && inst_ready) begin
        got_pc.push_back(inst_pc);
        got_data.push_back(inst_data);
        got_t.push_back(cyc);
      end
      tick();
    end
    chk("collect_count", 64'(got_pc.size()), 64'(n));
  endtask

  initial begin
    bit found;
    rst = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_lat = 0;
    tick(); tick();

    // Reset values
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_data", 64'(inst_data), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);

    // Streaming with same-cycle memory and decode always ready
    rst = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("stream_req_%0d", i), 64'(mem_req), 64'd1);
      chk($sformatf("stream_addr_%0d", i), 64'(mem_addr), 64'(i));
      if (i >= 1) begin
        chk($sformatf("stream_valid_%0d", i), 64'(inst_valid), 64'd1);
        chk($sformatf("stream_pc_%0d", i), 64'(inst_pc), 64'(i - 1));
        chk($sformatf("stream_data_%0d", i), 64'(inst_data), 64'(word_of(32'(i - 1))));
      end else begin
        chk("stream_first_valid", 64'(inst_valid), 64'd0);
      end
      tick();
    end

    // Backpressure: two entries buffered, request stops
    inst_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("bp_mem_req", 64'(mem_req), 64'd0);
    chk("bp_inst_valid", 64'(inst_valid), 64'd1);
    chk("bp_head_pc", 64'(inst_pc), 64'd0);
    chk("bp_next_addr", 64'(mem_addr), 64'd2);
    inst_ready = 1'b1;
    collect(6, 40);
    for (int k = 0; k < got_pc.size(); k++) begin
      chk($sformatf("bp_pc_%0d", k), 64'(got_pc[k]), 64'(k));
      chk($sformatf("bp_data_%0d", k), 64'(got_data[k]), 64'(word_of(32'(k))));
    end

    // Three-cycle memory latency
    mem_lat = 3; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("lat_req_%0d", j), 64'(mem_req), 64'd1);
      chk($sformatf("lat_addr_%0d", j), 64'(mem_addr), 64'd0);
      chk($sformatf("lat_valid_%0d", j), 64'(inst_valid), 64'd0);
      tick();
    end
    chk("lat_next_addr", 64'(mem_addr), 64'd1);
    chk("lat_first_valid", 64'(inst_valid), 64'd1);
    collect(3, 30);
    for (int k = 0; k < got_pc.size(); k++)
      chk($sformatf("lat_pc_%0d", k), 64'(got_pc[k]), 64'(k));
    for (int k = 1; k < got_t.size(); k++)
      chk($sformatf("lat_gap_%0d", k), 64'(got_t[k] - got_t[k-1]), 64'd4);

    // Redirect while the read of address 5 is pending and pc 4 is buffered
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (inst_valid && inst_pc == 32'd3) found = 1;
      else tick();
    end
    chk("redir_seen_pc3", 64'(found), 64'd1);
    tick();
    inst_ready = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (inst_valid && inst_pc == 32'd4 && mem_req && mem_addr == 32'd5) found = 1;
      else tick();
    end
    chk("redir_setup", 64'(found), 64'd1);
    chk("redir_setup_rvalid", 64'(mem_rvalid), 64'd0);
    redirect = 1'b1; redirect_pc = 32'h20; inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("redir_flush_valid", 64'(inst_valid), 64'd0);
    chk("redir_old_req", 64'(mem_req), 64'd1);
    chk("redir_old_addr", 64'(mem_addr), 64'd5);
    collect(2, 40);
    if (got_pc.size() == 2) begin
      chk("redir_pc0", 64'(got_pc[0]), 64'h20);
      chk("redir_pc1", 64'(got_pc[1]), 64'h21);
      chk("redir_data0", 64'(got_data[0]), 64'(word_of(32'h20)));
    end

    // Redirect coincident with a response and a pop
    mem_lat = 0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (inst_valid && mem_rvalid) found = 1;
      else tick();
    end
    chk("coinc_setup", 64'(found), 64'd1);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("coinc_valid", 64'(inst_valid), 64'd0);
    chk("coinc_req", 64'(mem_req), 64'd0);
    chk("coinc_addr", 64'(mem_addr), 64'h100);
    tick();
    chk("coinc_req2", 64'(mem_req), 64'd1);
    chk("coinc_addr2", 64'(mem_addr), 64'h100);
    tick();
    chk("coinc_out_valid", 64'(inst_valid), 64'd1);
    chk("coinc_out_pc", 64'(inst_pc), 64'h100);
    chk("coinc_out_data", 64'(inst_data), 64'(word_of(32'h100)));

    // PC wrap-around
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    collect(2, 20);
    if (got_pc.size() == 2) begin
      chk("wrap_pc0", 64'(got_pc[0]), 64'hFFFF_FFFF);
      chk("wrap_data0", 64'(got_data[0]), 64'(word_of(32'hFFFF_FFFF)));
      chk("wrap_pc1", 64'(got_pc[1]), 64'd0);
    end

    // Reset in the middle of an outstanding request
    mem_lat = 3;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req && !mem_rvalid) found = 1;
      else tick();
    end
    chk("midrst_setup", 64'(found), 64'd1);
    rst = 1'b1;
    tick();
    chk("midrst_req", 64'(mem_req), 64'd0);
    chk("midrst_valid", 64'(inst_valid), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst_req2", 64'(mem_req), 64'd1);
    chk("midrst_addr2", 64'(mem_addr), 64'd0);

    chk("fifo_protocol", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
